// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, width and issue-request definitions for the alu32 issue path
package alu_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   typedef enum logic [2:0] {ALU_ADD = 3'b000, ALU_SLL = 3'b001, ALU_AND = 3'b111} alu_op_t;
   typedef struct packed {
      logic [2:0]        op;
      logic [ADDR_W-1:0] rs1;
      logic [ADDR_W-1:0] rs2;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] imm;
      logic              use_imm;
   } issue_req_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 2R1W register file, R0 hardwired to zero, write-to-read bypass
module alu_regfile #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd
);
   logic [DATA_W-1:0] mem_q [NREGS];
   logic [DATA_W-1:0] mem_d [NREGS];
   always_comb begin
      mem_d = mem_q;
      if (we && wa != '0) mem_d[wa] = wd;
   end
   always_ff @(posedge clk) begin
      if (reset) mem_q <= '{default: '0};
      else mem_q <= mem_d;
   end
   assign rdata1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : mem_q[ra1];
   assign rdata2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : mem_q[ra2];
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand issue with scoreboard and one-entry output register toward alu32.
// Optional ALU_ISSUE_PERF_EN adds stall_cnt/issue_cnt performance counters.
module alu_issue_stage #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [2:0]        ALUop,
   output logic [ADDR_W-1:0] out_rd,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data
`ifdef ALU_ISSUE_PERF_EN
  ,output logic [31:0]       stall_cnt,
   output logic [31:0]       issue_cnt
`endif
);
   import alu_pkg::*;
   issue_req_t        req;
   logic [DATA_W-1:0] rd1, rd2;
   logic [NREGS-1:0]  pend_q, pend_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic              hazard, accept;
   assign req = '{op: in_op, rs1: in_rs1, rs2: in_rs2, rd: in_rd, imm: in_imm, use_imm: in_use_imm};
   alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_rf (
      .clk(clk), .reset(reset), .ra1(req.rs1), .ra2(req.rs2), .rdata1(rd1), .rdata2(rd2),
      .we(wb_en), .wa(wb_rd), .wd(wb_data)
   );
   // A write-back landing this cycle resolves the hazard through the bypass.
   always_comb begin
      hazard = (pend_q[req.rs1] && req.rs1 != '0 && !(wb_en && wb_rd == req.rs1))
            || (!req.use_imm && pend_q[req.rs2] && req.rs2 != '0 && !(wb_en && wb_rd == req.rs2));
      in_ready = !hazard && (!out_valid_q || out_ready);
      accept = in_valid && in_ready;
      out_valid_d = accept || (out_valid_q && !out_ready);
      a_d = accept ? rd1 : a_q;
      b_d = accept ? (req.use_imm ? req.imm : rd2) : b_q;
      op_d = accept ? req.op : op_q;
      rd_d = accept ? req.rd : rd_q;
      pend_d = pend_q;
      if (wb_en) pend_d[wb_rd] = 1'b0;
      if (accept && req.rd != '0) pend_d[req.rd] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
         out_valid_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
         rd_q <= '0;
      end else begin
         pend_q <= pend_d;
         out_valid_q <= out_valid_d;
         a_q <= a_d;
         b_q <= b_d;
         op_q <= op_d;
         rd_q <= rd_d;
      end
   end
   assign out_valid = out_valid_q;
   assign a = a_q;
   assign b = b_q;
   assign ALUop = op_q;
   assign out_rd = rd_q;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, issue_cnt_q, issue_cnt_d;
   always_comb begin
      stall_cnt_d = stall_cnt_q + 32'(in_valid && hazard);
      issue_cnt_d = issue_cnt_q + 32'(accept);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         issue_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end
   assign stall_cnt = stall_cnt_q;
   assign issue_cnt = issue_cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed + random issue traffic, scoreboard-checked against a register/pending-bit model
module tb_alu_issue_stage;
   logic        clk = 0, reset = 1;
   logic        in_valid = 0, in_ready, in_use_imm = 0, out_valid, out_ready = 0, wb_en = 0;
   logic [2:0]  in_op = 0, ALUop;
   logic [4:0]  in_rs1 = 0, in_rs2 = 0, in_rd = 0, out_rd, wb_rd = 0;
   logic [31:0] in_imm = 0, a, b, wb_data = 0;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] stall_cnt, issue_cnt;
`endif
   alu_issue_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_use_imm(in_use_imm),
      .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .ALUop(ALUop), .out_rd(out_rd),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef ALU_ISSUE_PERF_EN
     ,.stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  rd;
   } exp_t;
   exp_t        q[$];
   logic [31:0] mregs[32];
   bit          mpend[32];
   bit          mvalid;
   int          checks = 0, errors = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] mread(input logic [4:0] r);
      if (r == 0) return 0;
      if (wb_en && wb_rd == r) return wb_data;
      return mregs[r];
   endfunction
   function automatic bit mhaz(input logic [4:0] r);
      return mpend[r] && r != 0 && !(wb_en && wb_rd == r);
   endfunction
   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         mregs[i] = 0;
         mpend[i] = 0;
      end
      mvalid = 0;
      q.delete();
   endtask
   // One clock: drive at posedge+1, check and update the model at negedge.
   task automatic step(input logic v, input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic ui, input logic ordy,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd);
      bit er, acc;
      in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm; in_use_imm = ui;
      out_ready = ordy; wb_en = we; wb_rd = wrd; wb_data = wd;
      @(negedge clk);
      er = !(mhaz(rs1) || (!ui && mhaz(rs2))) && (!mvalid || ordy);
      chk("in_ready", {31'b0, in_ready}, {31'b0, er});
      chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
      acc = v && er;
      if (acc) q.push_back('{a: mread(rs1), b: ui ? imm : mread(rs2), op: op, rd: rd});
      mvalid = acc || (mvalid && !ordy);
      if (we && wrd != 0) mregs[wrd] = wd;
      if (we) mpend[wrd] = 0;
      if (acc && rd != 0) mpend[rd] = 1;
      @(posedge clk);
      #1;
   endtask
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: out_valid=1 with no pending expectation at %0t", $time);
            end else begin
               chk("a", a, q[0].a);
               chk("b", b, q[0].b);
               chk("ALUop", {29'b0, ALUop}, {29'b0, q[0].op});
               chk("out_rd", {27'b0, out_rd}, {27'b0, q[0].rd});
               if (out_ready) void'(q.pop_front());
            end
         end
      end
   end
   initial begin
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_a", a, 0);
      chk("rst_b", b, 0);
      chk("rst_ALUop", {29'b0, ALUop}, 0);
      chk("rst_out_rd", {27'b0, out_rd}, 0);
      reset = 0;
      step(1, 3'b000, 0, 0, 3, 0, 0, 1, 0, 0, 0);
      step(0, 3'b000, 0, 0, 0, 0, 0, 1, 1, 5, 32'h7FFFFFFF);
      step(1, 3'b000, 5, 0, 1, 1, 1, 1, 0, 0, 0);
      step(1, 3'b000, 0, 0, 4, 0, 0, 1, 0, 0, 0);
      step(1, 3'b000, 4, 0, 6, 0, 1, 1, 0, 0, 0);
      step(1, 3'b000, 4, 0, 6, 0, 1, 1, 1, 4, 32'h0000000F);
      repeat (3) step(1, 3'b111, 0, 0, 8, 32'h55, 1, 0, 0, 0, 0);
      step(1, 3'b111, 0, 0, 8, 32'h55, 1, 1, 0, 0, 0);
      step(1, 3'b001, 0, 0, 9, 32'h3, 1, 1, 0, 0, 0);
      step(0, 3'b000, 0, 0, 0, 0, 0, 1, 1, 0, 32'hFFFFFFFF);
      step(1, 3'b001, 0, 0, 10, 32'h1C, 1, 1, 0, 0, 0);
      step(1, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 3'b000, 0, 0, 2, 0, 0, 1, 0, 0, 0);
      step(0, 3'b000, 0, 0, 0, 0, 0, 1, 1, 7, 32'hA5A5A5A5);
      step(1, 3'b000, 0, 0, 7, 0, 0, 1, 0, 0, 0);
      in_valid = 0; out_ready = 0; wb_en = 0; reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      model_clear();
      chk("midrst_out_valid", {31'b0, out_valid}, 0);
      chk("midrst_a", a, 0);
      chk("midrst_out_rd", {27'b0, out_rd}, 0);
      step(1, 3'b000, 7, 0, 11, 0, 1, 1, 0, 0, 0);
      step(1, 3'b000, 7, 7, 12, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of alu32. Holds the 32x32 register file and reads rs1/rs2 with write-back bypass.
- Selects immediate vs register for operand b and tracks pending destinations with a scoreboard.
- Drives alu32 a/b/ALUop from a one-entry valid/ready pipeline register.
- alu32 result d returns through the wb_* port after downstream latching.

Parameters:
- DATA_W, 32, operand/register width
- NREGS, 32, number of architectural registers
- ADDR_W, 5, register index width (log2 NREGS)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  issue request valid
- in_ready  out  1  stage can accept a request this cycle
- in_op  in  3  ALUop (000 add, 001 sll, 111 and)
- in_rs1  in  ADDR_W  source register for a
- in_rs2  in  ADDR_W  source register for b
- in_rd  in  ADDR_W  destination register
- in_imm  in  DATA_W  immediate value
- in_use_imm  in  1  1: b = in_imm, 0: b = R[rs2]
- out_valid  out  1  a/b/ALUop/out_rd valid toward alu32
- out_ready  in  1  downstream consumes the entry
- a  out  DATA_W  alu32 operand a
- b  out  DATA_W  alu32 operand b
- ALUop  out  3  alu32 opcode
- out_rd  out  ADDR_W  destination tag travelling with the op
- wb_en  in  1  write-back strobe
- wb_rd  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back value (alu32 d)

Behaviour:
- Reset is synchronous, active-high. On reset:
  - out_valid=0; a=0, b=0, ALUop=000, out_rd=0.
  - All registers cleared to 0; all scoreboard bits cleared.
  - Reset mid-operation discards the held entry and all pending state.
- Register file: 2 read ports, 1 write port. R0 reads 0. wb_en with wb_rd=0 is ignored.
- Bypass: if wb_en and wb_rd==rs and rs!=0, the read returns wb_data in the same cycle.
- Scoreboard, one pending bit per register:
  - A source is a hazard when pend[rs]=1, rs!=0, and not (wb_en && wb_rd==rs).
  - rs2 is ignored when in_use_imm=1.
- in_ready = !hazard && (!out_valid || out_ready). This is combinational; in_ready must not depend on in_valid.
- Accept = in_valid && in_ready. On accept, next edge:
  - out_valid=1.
  - a = R[rs1] with bypass.
  - b = in_use_imm ? in_imm : R[rs2] with bypass.
  - ALUop = in_op; out_rd = in_rd.
  - pend[in_rd] set if in_rd!=0.
- Latency: request to out_valid is 1 cycle.
- If out_valid && out_ready and there is no accept, out_valid clears next edge.
- Outputs are held stable while out_valid && !out_ready.
- wb_en clears pend[wb_rd].
- Same-cycle set and clear of the same index: set wins, because the newest issue owns the register.
- Illegal in_op (not 000/001/111) is passed through unchanged; alu32 defines the result.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN
- Defined:
  - Adds output port stall_cnt [31:0], cleared on reset.
  - Increments each cycle where in_valid && hazard. Wraps 0xFFFFFFFF to 0.
  - Adds output port issue_cnt [31:0], which increments on each accept.
- Undefined: neither port exists and there is no counter logic. Functional behaviour is identical in both cases.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t enum: ALU_ADD=3'b000, ALU_SLL=3'b001, ALU_AND=3'b111.
  - DATA_W=32, ADDR_W=5 constants.
  - Issue request struct {op, rs1, rs2, rd, imm, use_imm}.
- Sub-module alu_regfile: 2R1W array with R0 hardwired to 0 and write-to-read bypass.
- The scoreboard and pipeline register stay in alu_issue_stage.

Test Plan:
- Reset, then issue add rs1=0, rs2=0, rd=3 → next cycle out_valid=1, a=0, b=0, ALUop=000, out_rd=3; pend[3]=1.
- wb R5=0x7FFFFFFF; issue add rs1=5, imm=1, use_imm=1 → a=0x7FFFFFFF, b=0x00000001 (alu32 gives 0x80000000, V=1).
- Issue rd=4, then issue rs1=4 with no wb → in_ready=0 (stall). Then wb_en, wb_rd=4, wb_data=0x0000000F → accepted the same cycle with a=0x0000000F (bypass).
- out_ready=0 with out_valid=1 for 3 cycles → a/b/ALUop unchanged and in_ready=0. Raise out_ready → next request accepted back-to-back.
- wb_en, wb_rd=0, wb_data=0xFFFFFFFF; issue sll rs1=0, imm=0x1C → a=0, b=0x0000001C. Issue rd=0 then rs1=0 → no stall.
- Assert reset while out_valid=1 and pend[7]=1 → next cycle out_valid=0 and R7=0. Issue rs1=7 → no stall, a=0.
